// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants and types for the systolic sequencer.
// Array size, feed length, FSM state encoding and load-port select codes.
package systolic_pkg;

  localparam int N          = 4;
  localparam int DEF_DATA_W = 32;
  localparam int FEED_LEN   = 3*N - 2;

  // Width of the feed counter; FEED_LEN-1 = 9 fits in 4 bits.
  localparam int T_W = 4;
  localparam logic [T_W-1:0] FEED_LAST = T_W'(FEED_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE
  } state_t;

  localparam logic LD_SEL_A = 1'b0;
  localparam logic LD_SEL_B = 1'b1;

  // Flat buffer index of element [r][c] in a row-major 4x4 matrix.
  function automatic logic [3:0] mat_idx(
    input logic [1:0] r,
    input logic [1:0] c
  );
    return {r, c};
  endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: registered, skewed operand lanes for the array.
// Ports: clk, rst, en (FEED state), t (feed counter), a_mat/b_mat
// (row-major operand buffers), row_op[i] = A[i][t-i], col_op[j] = B[t-j][j],
// both zero outside 0..3 or when en is low.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [T_W-1:0]              t,
  input  logic [N*N-1:0][DATA_W-1:0]  a_mat,
  input  logic [N*N-1:0][DATA_W-1:0]  b_mat,
  output logic [N-1:0][DATA_W-1:0]    row_op,
  output logic [N-1:0][DATA_W-1:0]    col_op
);

  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam logic [T_W-1:0] OFS = T_W'(g);

    logic [T_W-1:0]    k;
    logic              hit;
    logic [DATA_W-1:0] row_q;
    logic [DATA_W-1:0] col_q;

    // Lane g carries element k = t-g; the skew is the same for rows
    // and columns, so one window test serves both.
    assign k   = t - OFS;
    assign hit = en && (t >= OFS) && (k < T_W'(N));

    always_ff @(posedge clk) begin
      if (rst || !hit) begin
        row_q <= '0;
        col_q <= '0;
      end else begin
        row_q <= a_mat[mat_idx(OFS[1:0], k[1:0])];
        col_q <= b_mat[mat_idx(k[1:0], OFS[1:0])];
      end
    end

    assign row_op[g] = row_q;
    assign col_op[g] = col_q;
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequencer for the 4x4 output-stationary systolic array.
// Ports: ld_* host operand write port (IDLE only), start/busy/done control,
// array_clr/row_op/col_op/c_flat to the array, rd_addr/rd_data result read
// (1-cycle latency), run_count completed runs.
// Macro SYSTOLIC_SEQ_CTRL_PERF_EN enables the run and busy-cycle counters;
// without it run_count is tied to 0.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic                 ld_sel,
  input  logic [3:0]           ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 array_clr,
  output logic [4*DATA_W-1:0]  row_op,
  output logic [4*DATA_W-1:0]  col_op,
  input  logic [16*DATA_W-1:0] c_flat,
  input  logic [3:0]           rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic [15:0]          run_count
);

  localparam int D_W =
    (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [D_W-1:0] DRAIN_LAST =
    D_W'(DRAIN_CYCLES - 1);

  typedef logic [N*N-1:0][DATA_W-1:0] mat_t;

  state_t         state;
  state_t         state_n;
  logic [T_W-1:0] t;
  logic [D_W-1:0] dcnt;
  mat_t           a_buf;
  mat_t           b_buf;
  mat_t           c_buf;
  logic           ld_fire;

  logic [N-1:0][DATA_W-1:0] row_l;
  logic [N-1:0][DATA_W-1:0] col_l;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CLEAR;
      CLEAR:   state_n = FEED;
      FEED:    if (t == FEED_LAST) state_n = DRAIN;
      DRAIN:   if (dcnt == DRAIN_LAST) state_n = CAPTURE;
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counters free-run only inside their own state and rest at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      t    <= '0;
      dcnt <= '0;
    end else begin
      t    <= (state == FEED)  ? t + 1'b1    : '0;
      dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
    end
  end

  assign ld_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == CAPTURE);
  assign array_clr = rst || (state == CLEAR);
  assign ld_fire   = ld_valid && ld_ready;

  // A write accepted alongside start lands before CLEAR, so the run
  // that start launches already sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_buf <= '0;
      b_buf <= '0;
    end else if (ld_fire) begin
      unique case (1'b1)
        ld_sel == LD_SEL_A: a_buf[ld_addr] <= ld_data;
        ld_sel == LD_SEL_B: b_buf[ld_addr] <= ld_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_buf <= '0;
    end else if (state == CAPTURE) begin
      c_buf <= c_flat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= c_buf[rd_addr];
    end
  end

  systolic_skew_feeder #(
    .DATA_W (DATA_W)
  ) u_feeder (
    .clk    (clk),
    .rst    (rst),
    .en     (state == FEED),
    .t      (t),
    .a_mat  (a_buf),
    .b_mat  (b_buf),
    .row_op (row_l),
    .col_op (col_l)
  );

  assign row_op = row_l;
  assign col_op = col_l;

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
  logic [15:0] runs_q;
  logic [31:0] busy_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      runs_q      <= '0;
      busy_cycles <= '0;
    end else begin
      if (done) runs_q <= runs_q + 16'd1;
      if (busy) busy_cycles <= busy_cycles + 32'd1;
    end
  end

  assign run_count = runs_q;
`else
  assign run_count = '0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed bench for systolic_seq_ctrl.
// Includes a behavioural 4x4 output-stationary array driven by the DUT.
module tb_systolic_seq_ctrl;
  import systolic_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_sel;
  logic [3:0]    ld_addr;
  logic [W-1:0]  ld_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          array_clr;
  logic [4*W-1:0]  row_op;
  logic [4*W-1:0]  col_op;
  logic [16*W-1:0] c_flat;
  logic [3:0]    rd_addr;
  logic [W-1:0]  rd_data;
  logic [15:0]   run_count;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(
    .DATA_W       (W),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .array_clr (array_clr),
    .row_op    (row_op),
    .col_op    (col_op),
    .c_flat    (c_flat),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .run_count (run_count)
  );

  // Array: row data moves right, column data moves down.
  logic [W-1:0] ph [4][4];
  logic [W-1:0] pv [4][4];
  logic [W-1:0] acc[4][4];
  logic [W-1:0] hin[4][4];
  logic [W-1:0] vin[4][4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        hin[i][j] = row_op[i*W +: W];
        vin[i][j] = col_op[j*W +: W];
        if (j > 0) hin[i][j] = ph[i][j-1];
        if (i > 0) vin[i][j] = pv[i-1][j];
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (array_clr) begin
          acc[i][j] <= '0;
          ph[i][j]  <= '0;
          pv[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + hin[i][j] * vin[i][j];
          ph[i][j]  <= hin[i][j];
          pv[i][j]  <= vin[i][j];
        end
      end
    end
  end

  always_comb begin
    c_flat = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        c_flat[(4*i+j)*W +: W] = acc[i][j];
  end

  int checks = 0;
  int errors = 0;
  int nruns  = 0;

  logic [W-1:0] ma[4][4];
  logic [W-1:0] mb[4][4];

  logic [W-1:0] rtr[16][4];
  logic [W-1:0] ctr[16][4];
  logic         clr_tr[16];
  logic [W-1:0] rd_tr[16];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rc_exp(input int n);
`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    return 16'(n);
`else
    return 16'(n & 0);
`endif
  endfunction

  function automatic logic [W-1:0] gold(input int i, input int j);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s += ma[i][k] * mb[k][j];
    return s;
  endfunction

  task automatic ld(input logic sel, input int r, input int c,
                    input logic [W-1:0] d);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_addr  = 4'(r*4 + c);
    ld_data  = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    if (sel) mb[r][c] = d;
    else     ma[r][c] = d;
  endtask

  task automatic rd(input int idx, output logic [W-1:0] d);
    rd_addr = 4'(idx);
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic trace(input int n);
    if (n < 16) begin
      clr_tr[n] = array_clr;
      rd_tr[n]  = rd_data;
      for (int l = 0; l < 4; l++) begin
        rtr[n][l] = row_op[l*W +: W];
        ctr[n][l] = col_op[l*W +: W];
      end
    end
  endtask

  // Ends in the IDLE cycle following done.
  task automatic run_mm(output int lat);
    int n;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    ld_valid = 1'b0;
    n = 1;
    trace(n);
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      trace(n);
    end
    lat = n;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] d;
    for (int idx = 0; idx < 16; idx++) begin
      rd(idx, d);
      chk($sformatf("%s_c%0d", tag, idx), d, gold(idx/4, idx%4));
    end
  endtask

  task automatic skew_chk(input string tag);
    int t;
    int nbad;
    logic [W-1:0] er;
    logic [W-1:0] ec;
    nbad = 0;
    for (int n = 2; n < 14; n++) begin
      t = n - 3;
      for (int l = 0; l < 4; l++) begin
        er = '0;
        ec = '0;
        if (t - l >= 0 && t - l <= 3) begin
          er = ma[l][t-l];
          ec = mb[t-l][l];
        end
        if (rtr[n][l] !== er) nbad++;
        if (ctr[n][l] !== ec) nbad++;
      end
    end
    chk(tag, 64'(nbad), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nd;
    int wr;
    logic pend;
    logic clr1;
    logic [W-1:0] d;

    rst      = 1'b1;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    start    = 1'b0;
    rd_addr  = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_clr", array_clr, 1);
    chk("rst_ready", ld_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_row", 64'(row_op != '0), 0);
    chk("rst_col", 64'(col_op != '0), 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_rc", run_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_clr", array_clr, 0);

    // Identity A, B = 1..16 row-major.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ld(LD_SEL_A, r, c, (r == c) ? 32'd1 : 32'd0);
        ld(LD_SEL_B, r, c, 32'(r*4 + c + 1));
      end
    run_mm(lat);
    nruns++;
    chk("id_lat", 64'(lat), 14);
    chk("id_clr", clr_tr[1], 1);
    chk("id_clr_feed", clr_tr[2], 0);
    skew_chk("id_skew");
    chk("id_col2_t3", ctr[6][2], 7);
    chk("id_rc", run_count, rc_exp(nruns));
    check_all("id");
    rd(15, d);
    chk("id_c33", d, 16);

    // Dense: A[i][j] = i+j, B[i][j] = i*j.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ld(LD_SEL_A, r, c, 32'(r + c));
        ld(LD_SEL_B, r, c, 32'(r * c));
      end
    run_mm(lat);
    nruns++;
    chk("dn_lat", 64'(lat), 14);
    for (int n = 2; n < 6; n++)
      chk($sformatf("dn_row3_n%0d", n), rtr[n][3], 0);
    chk("dn_row3_t3", rtr[6][3], 3);
    skew_chk("dn_skew");
    check_all("dn");
    rd(15, d);
    chk("dn_c33", d, 96);
    chk("dn_rc", run_count, rc_exp(nruns));

    // Start and a write presented mid-FEED.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start    = 1'b1;
    ld_valid = 1'b1;
    ld_sel   = LD_SEL_B;
    ld_addr  = 4'd0;
    ld_data  = 32'd100;
    chk("bz_ready", ld_ready, 0);
    chk("bz_busy", busy, 1);
    nd = 0;
    wr = 0;
    for (int k = 0; k < 30; k++) begin
      pend = ld_valid && ld_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (pend) begin
        ld_valid = 1'b0;
        wr++;
      end
      if (done) nd++;
    end
    nruns++;
    chk("bz_done_cnt", 64'(nd), 1);
    chk("bz_wr_cnt", 64'(wr), 1);
    chk("bz_rc", run_count, rc_exp(nruns));
    check_all("bz");
    mb[0][0] = 32'd100;
    run_mm(lat);
    nruns++;
    check_all("wr");
    rd(12, d);
    chk("wr_c30", d, 300);

    // Back-to-back, second run with B doubled via the start-cycle write.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ld(LD_SEL_B, r, c, (r == 1 && c == 2) ? 32'd7 : 32'd0);
    run_mm(lat);
    nruns++;
    clr1 = clr_tr[1];
    chk("b2b_idle", ld_ready, 1);
    rd_addr  = 4'd14;
    ld_valid = 1'b1;
    ld_sel   = LD_SEL_B;
    ld_addr  = 4'd6;
    ld_data  = 32'd14;
    mb[1][2] = 32'd14;
    run_mm(lat);
    nruns++;
    chk("b2b_lat", 64'(lat), 14);
    chk("b2b_clr1", clr1, 1);
    chk("b2b_clr2", clr_tr[1], 1);
    chk("b2b_first_c32", rd_tr[1], 28);
    check_all("b2b");
    rd(14, d);
    chk("b2b_c32", d, 56);
    chk("b2b_rc", run_count, rc_exp(nruns));

    // Reset at FEED t=5.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rs_pre_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_ready", ld_ready, 1);
    chk("rs_done", done, 0);
    chk("rs_row", 64'(row_op != '0), 0);
    chk("rs_col", 64'(col_op != '0), 0);
    chk("rs_rc", run_count, 0);
    nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("rs_nodone", 64'(nd), 0);
    rd(15, d);
    chk("rs_c33", d, 0);
    rd(14, d);
    chk("rs_c32", d, 0);
    nruns = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
    run_mm(lat);
    nruns++;
    check_all("rs");
    chk("rs_rc_run", run_count, rc_exp(nruns));

`ifdef SYSTOLIC_SEQ_CTRL_PERF_EN
    force dut.runs_q = 16'hFFFF;
    #1;
    release dut.runs_q;
    chk("wrap_pre", run_count, 16'hFFFF);
    run_mm(lat);
    chk("wrap_rc", run_count, 0);
`else
    run_mm(lat);
    chk("norc_rc", run_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
